// File: rtl/mole_spawner.sv
// Whack-a-mole spawner: lights one pseudo-random LED per window, blank gap between moles, counts misses.
// Optional macro SPEEDUP_EN: each hit shortens the mole window by STEP down to MIN_TIME.
module mole_spawner #(
    parameter int          N_LEDS    = 18,
    parameter int          MOLE_TIME = 50_000_000,
    parameter int          GAP_TIME  = 12_500_000,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MIN_TIME  = 12_500_000,
    parameter int          STEP      = 2_500_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hit,
    output logic [N_LEDS-1:0] ledr,
    output logic [4:0]        mole_idx,
    output logic              active,
    output logic              miss,
    output logic [7:0]        miss_cnt
);

    localparam logic [1:0]        IDLE      = 2'd0;
    localparam logic [1:0]        GAP       = 2'd1;
    localparam logic [1:0]        SHOW      = 2'd2;
    localparam logic [15:0]       LFSR_INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [5:0]        NL        = 6'(N_LEDS);
    localparam logic [31:0]       GAP_LOAD  = 32'(GAP_TIME - 1);
    localparam logic [31:0]       MOLE_WIN  = 32'(MOLE_TIME);
    localparam logic [N_LEDS-1:0] LED_ONE   = N_LEDS'(1);

    if (N_LEDS < 2 || N_LEDS > 32 || MOLE_TIME < 2 || GAP_TIME < 1 ||
        MIN_TIME < 1 || STEP < 0) begin : g_param_check
        $error("mole_spawner: illegal parameter set");
    end

    logic [1:0]  state;
    logic [31:0] timer;
    logic [15:0] lfsr;
    logic [31:0] win;
    logic [5:0]  cand_w;
    logic [4:0]  cand;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // LFSR runs every cycle regardless of state so mole order depends on player timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lfsr <= LFSR_INIT;
        else
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    always_comb begin
        cand_w = {1'b0, lfsr[4:0]};
        if (cand_w >= NL) cand_w = cand_w - NL;
        if (cand_w >= NL) cand_w = 6'd0;
        if (cand_w[4:0] == mole_idx)
            cand_w = (cand_w == NL - 6'd1) ? 6'd0 : cand_w + 6'd1;
        cand = cand_w[4:0];
    end

`ifdef SPEEDUP_EN
    localparam logic [31:0] MIN_WIN    = 32'(MIN_TIME);
    localparam logic [31:0] STEP_W     = 32'(STEP);
    localparam logic [31:0] SHRINK_MIN = 32'(MIN_TIME + STEP);

    function automatic logic [31:0] shrink_clamp(input logic [31:0] w);
        return (w >= SHRINK_MIN) ? w - STEP_W : MIN_WIN;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            win <= MOLE_WIN;
        else if (state == IDLE && start)
            win <= MOLE_WIN;
        else if (state == SHOW && start && hit)
            win <= shrink_clamp(win);
    end
`else
    assign win = MOLE_WIN;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            ledr     <= '0;
            mole_idx <= '0;
            miss     <= 1'b0;
            miss_cnt <= '0;
        end else begin
            miss <= 1'b0;
            case (state)
                IDLE: begin
                    ledr <= '0;
                    if (start) begin
                        state <= GAP;
                        timer <= GAP_LOAD;
                    end
                end
                GAP: begin
                    ledr <= '0;
                    if (!start) begin
                        state <= IDLE;
                    end else if (timer == '0) begin
                        state    <= SHOW;
                        mole_idx <= cand;
                        ledr     <= LED_ONE << cand;
                        timer    <= win - 32'd1;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                SHOW: begin
                    // a hit on the timeout cycle wins over the miss
                    if (!start) begin
                        state <= IDLE;
                        ledr  <= '0;
                    end else if (hit) begin
                        state <= GAP;
                        ledr  <= '0;
                        timer <= GAP_LOAD;
                    end else if (timer == '0) begin
                        state    <= GAP;
                        ledr     <= '0;
                        timer    <= GAP_LOAD;
                        miss     <= 1'b1;
                        miss_cnt <= sat_inc(miss_cnt);
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ledr  <= '0;
                end
            endcase
        end
    end

    assign active = (state == SHOW);

endmodule

// File: tb/tb_mole_spawner.sv
// Directed bench for mole_spawner with MOLE_TIME=8, GAP_TIME=4, SEED=1; reference LFSR predicts mole order.
module tb_mole_spawner;

    localparam int N_LEDS    = 18;
    localparam int MOLE_TIME = 8;
    localparam int GAP_TIME  = 4;
    localparam int MIN_TIME  = 4;
    localparam int STEP      = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              hit;
    logic [N_LEDS-1:0] ledr;
    logic [4:0]        mole_idx;
    logic              active;
    logic              miss;
    logic [7:0]        miss_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    int          ref_idx  = 0;
    int          exp_idx  = 0;
    int          exp_cnt  = 0;
    int          lens[4];
    logic [15:0] ml;

    always #5 clk = ~clk;

    mole_spawner #(
        .N_LEDS   (N_LEDS),
        .MOLE_TIME(MOLE_TIME),
        .GAP_TIME (GAP_TIME),
        .SEED     (16'h0001),
        .MIN_TIME (MIN_TIME),
        .STEP     (STEP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .hit     (hit),
        .ledr    (ledr),
        .mole_idx(mole_idx),
        .active  (active),
        .miss    (miss),
        .miss_cnt(miss_cnt)
    );

    // Reference LFSR: x^16 taps 15,13,12,10, shift left, seeded with 1
    always @(posedge clk or posedge rst) begin
        if (rst) ml <= 16'h0001;
        else     ml <= {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
    end

    function automatic int cand_of(input logic [15:0] l, input int prev);
        int c;
        c = int'(l[4:0]);
        if (c >= N_LEDS) c = c - N_LEDS;
        if (c >= N_LEDS) c = 0;
        if (c == prev) c = (c == N_LEDS - 1) ? 0 : c + 1;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the first GAP cycle; returns on the first SHOW cycle.
    task automatic wait_mole();
        for (int i = 0; i < GAP_TIME; i++) begin
            check("gap_ledr", 32'(ledr), 32'd0);
            check("gap_active", 32'(active), 32'd0);
            if (i == 1) check("miss_one_cycle", 32'(miss), 32'd0);
            if (i == GAP_TIME - 1) exp_idx = cand_of(ml, ref_idx);
            tick();
        end
        check("mole_idx", 32'(mole_idx), 32'(exp_idx));
        check("mole_ledr", 32'(ledr), 32'd1 << exp_idx);
        check("mole_active", 32'(active), 32'd1);
        check("no_repeat", 32'(int'(mole_idx) != ref_idx), 32'd1);
        ref_idx = exp_idx;
    endtask

    // Measures one SHOW window; hit_cyc < 0 leaves hit untouched.
    task automatic show(input int hit_cyc, input int exp_len, input logic exp_miss);
        int c;
        c = 0;
        while (ledr != '0 && c < 40) begin
            check("show_miss_low", 32'(miss), 32'd0);
            if (hit_cyc >= 0) hit = (c == hit_cyc);
            tick();
            c++;
        end
        if (hit_cyc >= 0) hit = 1'b0;
        check("show_len", 32'(c), 32'(exp_len));
        check("end_miss", 32'(miss), 32'(exp_miss));
        check("end_active", 32'(active), 32'd0);
        if (exp_miss) exp_cnt = (exp_cnt == 255) ? 255 : exp_cnt + 1;
        check("miss_cnt", 32'(miss_cnt), 32'(exp_cnt));
    endtask

    // Called on a GAP cycle: drop start into IDLE, then restart into GAP.
    task automatic toggle_start();
        start = 1'b0;
        tick();
        check("idle_ledr", 32'(ledr), 32'd0);
        check("idle_active", 32'(active), 32'd0);
        tick();
        start = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SPEEDUP_EN
        lens = '{8, 6, 4, 4};
`else
        lens = '{8, 8, 8, 8};
`endif
        rst   = 1'b1;
        start = 1'b0;
        hit   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ledr", 32'(ledr), 32'd0);
        check("rst_idx", 32'(mole_idx), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_miss", 32'(miss), 32'd0);
        check("rst_cnt", 32'(miss_cnt), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_no_start", 32'(ledr), 32'd0);
        start = 1'b1;
        tick();

        for (int m = 0; m < 3; m++) begin
            wait_mole();
            show(-1, MOLE_TIME, 1'b1);
        end

        // hit on the timeout cycle, then hit on third SHOW cycle
        wait_mole();
        show(MOLE_TIME - 1, MOLE_TIME, 1'b0);
        wait_mole();
        show(2, 3, 1'b0);

        // hit held through the gap ends the next SHOW after one cycle
        hit = 1'b1;
        wait_mole();
        show(-1, 1, 1'b0);
        hit = 1'b0;

        toggle_start();
        for (int k = 0; k < 3; k++) begin
            wait_mole();
            show(lens[k] - 1, lens[k], 1'b0);
        end
        wait_mole();
        show(-1, lens[3], 1'b1);

        toggle_start();
        wait_mole();
        show(-1, MOLE_TIME, 1'b1);

        // abort mid-SHOW
        wait_mole();
        tick();
        start = 1'b0;
        tick();
        check("abort_ledr", 32'(ledr), 32'd0);
        check("abort_miss", 32'(miss), 32'd0);
        check("abort_active", 32'(active), 32'd0);
        check("abort_cnt", 32'(miss_cnt), 32'(exp_cnt));
        repeat (GAP_TIME + 2) tick();
        check("abort_idle_ledr", 32'(ledr), 32'd0);
        check("abort_idle_active", 32'(active), 32'd0);
        start = 1'b1;
        tick();
        wait_mole();
        show(-1, MOLE_TIME, 1'b1);

        // saturation: 260 unhit moles at GAP_TIME+MOLE_TIME cycles each
        repeat (260 * (GAP_TIME + MOLE_TIME)) tick();
        check("sat_miss", 32'(miss), 32'd1);
        check("sat_cnt", 32'(miss_cnt), 32'd255);

        // asynchronous reset in the middle of a SHOW
        repeat (GAP_TIME + 2) tick();
        check("pre_rst_active", 32'(active), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_ledr", 32'(ledr), 32'd0);
        check("async_rst_active", 32'(active), 32'd0);
        check("async_rst_miss", 32'(miss), 32'd0);
        check("async_rst_cnt", 32'(miss_cnt), 32'd0);
        check("async_rst_idx", 32'(mole_idx), 32'd0);
        start = 1'b0;
        rst   = 1'b0;
        for (int i = 0; i < GAP_TIME + 3; i++) begin
            tick();
            check("post_rst_ledr", 32'(ledr), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mole_spawner.md
Name: mole_spawner

Overview:
- Upstream stage of the whack-a-mole game logic. Generates the LED pattern `ledr` that the hit detector compares against `SW_pressed`.
- Lights one pseudo-random LED (one-hot across 18 positions) for a timed window, then a blank gap, and repeats.
- The window ends early when the downstream hit flag (`point_1`) is asserted.
- Reports missed moles as a one-cycle pulse and keeps a saturating miss counter.

Parameters:
- N_LEDS, 18, number of LED/switch positions; `mole_idx` width is fixed at 5 bits, so N_LEDS ≤ 32.
- MOLE_TIME, 50_000_000, cycles a mole stays lit when not hit (≥ 2).
- GAP_TIME, 12_500_000, cycles of blank `ledr` between moles (≥ 1).
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.
- MIN_TIME, 12_500_000, lower bound for the mole window (used only with SPEEDUP_EN).
- STEP, 2_500_000, window decrement per hit (used only with SPEEDUP_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  level; game running while high.
- hit  in  1  hit flag from the game logic, connected to `point_1`.
- ledr  out  N_LEDS  one-hot mole LED; all zero when no mole is shown.
- mole_idx  out  5  index of the current or last mole, 0..N_LEDS-1.
- active  out  1  high while in SHOW.
- miss  out  1  one-cycle pulse when a mole times out unhit.
- miss_cnt  out  8  saturating count of misses.

Behaviour:
- Reset (async, immediate) values:
  - `ledr` = 0, `mole_idx` = 0, `active` = 0, `miss` = 0, `miss_cnt` = 0.
  - State = IDLE, timer = 0, LFSR = SEED (or 16'hACE1 if SEED = 0).
  - Window length = MOLE_TIME.
- LFSR:
  - 16-bit Fibonacci, free-running every cycle from reset in all states.
  - Shift left; `bit0` = `l[15]` ^ `l[13]` ^ `l[12]` ^ `l[10]`.
- Candidate index:
  - `c` = `l[4:0]`; if `c` ≥ N_LEDS then `c` = `c` − N_LEDS; if still ≥ N_LEDS then `c` = 0.
  - If `c` equals the current `mole_idx`, use `c`+1, wrapping N_LEDS−1 → 0. The same LED never lights twice in a row.
- IDLE:
  - `ledr` = 0.
  - When `start`=1: go to GAP, timer = GAP_TIME−1.
- GAP:
  - `ledr` = 0; timer decrements each cycle.
  - When timer = 0: go to SHOW; `mole_idx` = candidate; `ledr` = 1<<candidate; `active` = 1; timer = window−1.
  - `ledr` is therefore zero for exactly GAP_TIME cycles.
- SHOW, evaluated each cycle with priority in this order:
  - `start`=0: go to IDLE, `ledr` = 0, no `miss`.
  - `hit`=1: go to GAP, `ledr` = 0 on the next edge, no `miss`.
  - timer = 0: go to GAP, `ledr` = 0, `miss` pulses for exactly 1 cycle, `miss_cnt` increments and saturates at 255.
  - Otherwise timer decrements.
- `hit` and timeout in the same cycle: counts as a hit, no `miss`.
- `hit` in IDLE or GAP is ignored.
- A `hit` held high across the following GAP has no effect until the next SHOW. Such a held hit ends that next SHOW on its first cycle; this is intentional and matches the level-sensitive downstream flag.
- `start` deasserted in GAP: go to IDLE on the next edge.
- Output latency: `ledr` is registered and changes one edge after the triggering condition.

Optional Feature:
- Macro: SPEEDUP_EN.
- Defined:
  - Each accepted hit reduces the window by STEP, clamped at MIN_TIME.
  - The new window takes effect from the next SHOW.
  - The window resets to MOLE_TIME on `rst` and on every IDLE→GAP transition.
- Undefined: the window is constant MOLE_TIME; the STEP and MIN_TIME logic is not instantiated.

Test Plan:
- Parameters for all scenarios: MOLE_TIME=8, GAP_TIME=4, SEED=16'h0001.
- Reset: assert `rst` mid-SHOW → `ledr`, `active`, `miss`, `miss_cnt` go to 0 immediately without a clock edge; after release with `start`=0, `ledr` stays 0.
- No hits: `start`=1 from cycle 0 → `ledr` 0 for 4 cycles, then one-hot for 8 cycles. `miss` is high for 1 cycle at the end of each window and `miss_cnt` counts 1, 2, 3 over three moles. `mole_idx` matches a reference LFSR model and never repeats consecutively.
- Hit: pulse `hit` for 1 cycle on the 3rd SHOW cycle → `ledr` = 0 on the next edge, `miss` stays 0, next mole appears 4 cycles later.
- Simultaneous events: `hit`=1 exactly on the timeout cycle → no `miss`, `miss_cnt` unchanged. `hit` held high during GAP → no effect until SHOW; SHOW then lasts 1 cycle.
- Saturation and abort: force 260 misses → `miss_cnt` = 255. Drop `start` mid-SHOW → `ledr` = 0 next edge, no `miss`, state IDLE.
- SPEEDUP_EN with STEP=2, MIN_TIME=4: three consecutive hits → SHOW windows of 8, 6, 4, 4 cycles. Toggle `start` off/on → window back to 8.
